gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Synthesizable, self-checking stimulus/response engine for 2-input logic gates.
- Drives the gate's a/b inputs through all four input combinations, waits a settle window, samples the gate output c, and compares it with the expected truth-table value.
- Counts mismatches and reports pass/fail.
- Hardware counterpart to the team's simulation testbenches: it sits on the driving side of a gate DUT (a_out/b_out -> DUT a/b, DUT c -> c_in) for on-chip or FPGA bring-up.

Parameters:
- SETTLE_CYCLES, 2, cycles a/b are held before c_in is sampled; legal range 1..255.
- LOOPS, 1, number of full 4-vector passes per run; legal range 1..65535.
- ERR_W, 8, width of err_count; the count saturates at 2^ERR_W-1.

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; honoured only in IDLE or DONE
- op_sel  input  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 treated as AND
- c_in  input  1  DUT output under test
- a_out  output  1  drive to DUT input a
- b_out  output  1  drive to DUT input b
- busy  output  1  run in progress
- done  output  1  run finished; level, held until next start or rst
- pass  output  1  valid when done=1; 1 iff err_count==0
- mismatch  output  1  one-cycle pulse per failing sample
- err_count  output  ERR_W  saturating mismatch count for the current run
- first_fail  output  2  vector index {a,b} of the first mismatch; valid when err_count!=0
- vec_idx  output  2  current vector index; a_out=vec_idx[1], b_out=vec_idx[0]

Behaviour:
- Reset (rst=1 at a clock edge) applies regardless of state, including mid-run.
  - State returns to IDLE.
  - All outputs go to 0: a_out, b_out, busy, done, pass, mismatch, err_count, first_fail, vec_idx.
  - Internal settle and loop counters clear to 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1:
  - Latch op_sel.
  - Clear err_count, first_fail, loop counter and settle counter.
  - Set vec_idx=0, so a_out=b_out=0.
  - busy=1, done=0, pass=0.
  - Go to SETTLE.
- SETTLE:
  - Settle counter increments each cycle.
  - When it equals SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - c_in is sampled at the edge leaving SAMPLE and compared with f(op_sel_latched, a_out, b_out).
  - On mismatch, at that same edge:
    - mismatch=1 for exactly the following cycle.
    - err_count increments, saturating.
    - If err_count was 0, first_fail takes vec_idx.
  - If vec_idx==3 and this is the last loop (loop counter==LOOPS-1), go to DONE.
  - If vec_idx==3 and loops remain, loop counter increments, vec_idx wraps 3->0, settle counter clears, go to SETTLE.
  - Otherwise vec_idx increments, settle counter clears, go to SETTLE.
- a_out/b_out are registered and change only on the SAMPLE-exit edge, or on the start edge.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a_out/b_out return to 0.
  - The state holds until start or rst.
- Latency: done rises 4*LOOPS*(SETTLE_CYCLES+1) cycles after the edge that accepts start. With defaults this is 12.
- A run covers vectors in the order 00, 01, 10, 11 on {a_out,b_out}, repeated LOOPS times.
- Boundary conditions:
  - start while busy: ignored, no effect on any state.
  - op_sel changes mid-run: ignored; only the value latched at start is used.
  - start and rst in the same cycle: rst wins.
  - start asserted in DONE: restarts the run, and on that edge done drops and counters clear.
  - start held high continuously: a new run begins the cycle after each DONE entry. DONE lasts one cycle in this case, but done is still visibly high for that cycle.
  - err_count saturation: once at 2^ERR_W-1 it stays there; mismatch pulses continue to fire.

Test Plan:
1. Correct AND DUT, op_sel=0, defaults, start pulse -> a/b sequence 00,01,10,11 with each vector held 3 cycles; done=1 exactly 12 cycles after start; pass=1, err_count=0, no mismatch pulses.
2. c_in tied 0, op_sel=1 (OR) -> mismatch pulses at vectors 01, 10, 11; err_count=3, first_fail=2'b01, pass=0.
3. LOOPS=100, ERR_W=8, c_in tied 1, op_sel=0 -> 300 raw mismatches (3 per loop), err_count saturates at 255; done after 1200 cycles; pass=0.
4. rst asserted during SETTLE of vector 10 -> next edge all outputs 0 and state IDLE; a fresh start then completes a full correct run.
5. start pulsed and op_sel toggled while busy with a correct XOR DUT and op_sel=2 at start -> run unaffected, pass=1, done at cycle 12.
6. After a failing run, start again with the DUT corrected -> on the start edge done=0 and err_count=0; run ends with pass=1.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Stimulus/response engine for a 2-input gate: walks {a,b} through 00,01,10,11,
// samples c after a settle window and counts mismatches against the selected function.
module gate_vector_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op_sel,
   input  logic             c_in,
   output logic             a_out,
   output logic             b_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       first_fail,
   output logic [1:0]       vec_idx,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_settle_cnt;
   logic [15:0]       r_loop_cnt;
   logic [2:0]        r_op;
   logic [1:0]        r_vec;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic              r_mismatch;
   logic [ERR_W-1:0]  r_err;
   logic [1:0]        r_first_fail;

   logic              w_start_ok;
   logic              w_expected;
   logic              w_fail;
   logic              w_last_vec;
   logic              w_last_loop;
   logic              w_settle_end;
   logic              w_err_sat;

   assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_vec   = (r_vec == 2'd3);
   assign w_last_loop  = (r_loop_cnt == 16'(LOOPS - 1));
   assign w_settle_end = (r_settle_cnt == 8'(SETTLE_CYCLES - 1));
   assign w_err_sat    = &r_err;

   // Expected gate output for the current vector; codes 6/7 fall back to AND.
   always_comb begin
      w_expected = r_vec[1] & r_vec[0];
      case (r_op)
         3'd0:    w_expected =   r_vec[1] & r_vec[0];
         3'd1:    w_expected =   r_vec[1] | r_vec[0];
         3'd2:    w_expected =   r_vec[1] ^ r_vec[0];
         3'd3:    w_expected = ~(r_vec[1] & r_vec[0]);
         3'd4:    w_expected = ~(r_vec[1] | r_vec[0]);
         3'd5:    w_expected = ~(r_vec[1] ^ r_vec[0]);
         default: w_expected =   r_vec[1] & r_vec[0];
      endcase
   end

   assign w_fail = (r_state == S_SAMPLE) && (c_in != w_expected);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SETTLE;
         S_SETTLE: if (w_settle_end) w_next = S_SAMPLE;
         S_SAMPLE: w_next = (w_last_vec && w_last_loop) ? S_DONE : S_SETTLE;
         S_DONE:   if (start) w_next = S_SETTLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_settle_cnt <= 8'd0;
         r_loop_cnt   <= 16'd0;
         r_op         <= 3'd0;
         r_vec        <= 2'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_mismatch   <= 1'b0;
         r_err        <= '0;
         r_first_fail <= 2'd0;
      end else begin
         r_mismatch <= 1'b0;
         if (w_start_ok) begin
            r_op         <= op_sel;
            r_err        <= '0;
            r_first_fail <= 2'd0;
            r_loop_cnt   <= 16'd0;
            r_settle_cnt <= 8'd0;
            r_vec        <= 2'd0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
         end else if (r_state == S_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
         end else if (r_state == S_SAMPLE) begin
            if (w_fail) begin
               r_mismatch <= 1'b1;
               if (!w_err_sat) r_err <= r_err + {{(ERR_W-1){1'b0}}, 1'b1};
               if (r_err == '0) r_first_fail <= r_vec;
            end
            r_settle_cnt <= 8'd0;
            if (w_last_vec && w_last_loop) begin
               // Run ends: park the drive lines at 0 and publish the verdict.
               r_vec  <= 2'd0;
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (r_err == '0) && !w_fail;
            end else begin
               if (w_last_vec) r_loop_cnt <= r_loop_cnt + 16'd1;
               r_vec <= r_vec + 2'd1;
            end
         end
      end
   end

   assign a_out      = r_vec[1];
   assign b_out      = r_vec[0];
   assign vec_idx    = r_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign mismatch   = r_mismatch;
   assign err_count  = r_err;
   assign first_fail = r_first_fail;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: a default instance driven by a
// behavioural gate (or stuck c), plus a LOOPS=100 instance for saturation.
module tb_gate_vector_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op_sel = 3'd0;
   logic       c_in;
   logic       a_out, b_out, busy, done, pass, mismatch;
   logic [7:0] err_count;
   logic [1:0] first_fail, vec_idx, state_dbg;

   logic       start_l = 1'b0;
   logic       c_in_l;
   logic       a_out_l, b_out_l, busy_l, done_l, pass_l, mismatch_l;
   logic [7:0] err_count_l;
   logic [1:0] first_fail_l, vec_idx_l, state_dbg_l;

   int         c_mode = 0;   // 0: behavioural gate, 1: stuck 0, 2: stuck 1
   logic [2:0] m_op = 3'd0;  // function the behavioural gate implements
   int         checks = 0;
   int         failures = 0;
   int         mism;
   int         cycles;

   always #5 clk = ~clk;

   gate_vector_checker dut (
      .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .c_in(c_in),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
      .mismatch(mismatch), .err_count(err_count), .first_fail(first_fail),
      .vec_idx(vec_idx), .state_dbg(state_dbg)
   );

   gate_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(100), .ERR_W(8)) dut_l (
      .clk(clk), .rst(rst), .start(start_l), .op_sel(3'd0), .c_in(c_in_l),
      .a_out(a_out_l), .b_out(b_out_l), .busy(busy_l), .done(done_l), .pass(pass_l),
      .mismatch(mismatch_l), .err_count(err_count_l), .first_fail(first_fail_l),
      .vec_idx(vec_idx_l), .state_dbg(state_dbg_l)
   );

   function automatic logic gate_f(input logic [2:0] op, input logic a, input logic b);
      case (op)
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         default: return a & b;
      endcase
   endfunction

   always_comb begin
      c_in = gate_f(m_op, a_out, b_out);
      if (c_mode == 1) c_in = 1'b0;
      if (c_mode == 2) c_in = 1'b1;
   end
   assign c_in_l = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_steps(input int n, output int m);
      m = 0;
      repeat (n) begin
         step();
         m += int'(mismatch);
      end
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      check("reset_outputs", {a_out, b_out, busy, done, pass, mismatch, err_count, first_fail, vec_idx}, 0);
      check("reset_state", state_dbg, 0);
      rst = 1'b0;

      // 1: correct AND gate, vector timing and 12-cycle latency
      c_mode = 0; m_op = 3'd0; op_sel = 3'd0;
      do_start();
      check("t1_busy_at_start", busy, 1);
      check("t1_ab_at_start", {a_out, b_out}, 0);
      mism = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         mism += int'(mismatch);
         if (k < 12) begin
            check("t1_vec", {a_out, b_out}, k / 3);
            check("t1_done_low", done, 0);
         end
      end
      check("t1_done", done, 1);
      check("t1_pass", pass, 1);
      check("t1_err", err_count, 0);
      check("t1_mism_pulses", mism, 0);
      check("t1_busy_end", busy, 0);
      check("t1_ab_end", {a_out, b_out}, 0);
      step();
      check("t1_done_held", done, 1);

      // 2: stuck-0 output against OR
      c_mode = 1; m_op = 3'd1; op_sel = 3'd1;
      do_start();
      check("t2_done_dropped", done, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         check("t2_mismatch_pulse", mismatch, (k == 6 || k == 9 || k == 12) ? 1 : 0);
      end
      check("t2_done", done, 1);
      check("t2_err", err_count, 3);
      check("t2_first_fail", first_fail, 1);
      check("t2_pass", pass, 0);

      // 6: restart after failure with a corrected DUT
      c_mode = 0;
      do_start();
      check("t6_done_cleared", done, 0);
      check("t6_err_cleared", err_count, 0);
      check("t6_first_fail_cleared", first_fail, 0);
      run_steps(12, mism);
      check("t6_done", done, 1);
      check("t6_pass", pass, 1);
      check("t6_err", err_count, 0);

      // 5: XOR run with start pulses and op_sel churn while busy
      c_mode = 0; m_op = 3'd2; op_sel = 3'd2;
      do_start();
      for (int k = 1; k <= 12; k++) begin
         start = (k == 4) || (k == 7);
         op_sel = 3'(k);
         step();
         if (k < 12) check("t5_done_low", done, 0);
      end
      start = 1'b0; op_sel = 3'd0;
      check("t5_done", done, 1);
      check("t5_pass", pass, 1);
      check("t5_err", err_count, 0);

      // 4: reset during SETTLE of vector 10
      c_mode = 2; m_op = 3'd0; op_sel = 3'd0;
      do_start();
      repeat (7) step();
      check("t4_pre_vec", {a_out, b_out}, 2);
      check("t4_pre_err", err_count, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_reset_outputs", {a_out, b_out, busy, done, pass, mismatch, err_count, first_fail, vec_idx}, 0);
      check("t4_reset_state", state_dbg, 0);
      step();
      check("t4_idle_holds", busy, 0);
      c_mode = 0;
      do_start();
      run_steps(12, mism);
      check("t4_rerun_done", done, 1);
      check("t4_rerun_pass", pass, 1);
      check("t4_rerun_mism", mism, 0);

      // start and rst together: rst wins
      start = 1'b1; rst = 1'b1;
      step();
      start = 1'b0; rst = 1'b0;
      check("start_rst_state", state_dbg, 0);
      check("start_rst_busy_done", {busy, done}, 0);

      // start held high: one-cycle DONE then immediate restart
      start = 1'b1;
      step();
      run_steps(12, mism);
      check("held_done_visible", done, 1);
      step();
      check("held_restart_busy", busy, 1);
      check("held_restart_done", done, 0);
      start = 1'b0;
      run_steps(12, mism);
      check("held_second_done", done, 1);
      check("held_second_pass", pass, 1);

      // 3: LOOPS=100, stuck-1 against AND, err_count saturation
      start_l = 1'b1;
      step();
      start_l = 1'b0;
      cycles = 0;
      mism = 0;
      while (!done_l && cycles < 1300) begin
         step();
         cycles++;
         mism += int'(mismatch_l);
      end
      check("t3_latency", cycles, 1200);
      check("t3_raw_mismatches", mism, 300);
      check("t3_err_saturated", err_count_l, 255);
      check("t3_pass", pass_l, 0);
      check("t3_first_fail", first_fail_l, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
